twi_master: RTL
===============

Name: twi_master

Overview:
- Single-master TWI (I2C) initiator. It is the counterpart of the TWI slave in the I2C IP.
- Runs one transaction per request: START, 7-bit address + R/W, then exactly one data byte written or read, then STOP.
- Drives SCL push-pull and SDA open-drain. Sits between the system-side control logic and the external TWI bus.

Parameters:
- SIZE_ADDR, 7, slave address width.
- SIZE_DATA, 8, data byte width.
- CLK_DIV, 4, i_clk cycles per SCL quarter-period. Must be >= 2. SCL period = 4*CLK_DIV cycles.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle request pulse, accepted only in IDLE.
- i_rw  in  1  0 = write, 1 = read. Sampled with i_start.
- i_addr  in  SIZE_ADDR  target address. Sampled with i_start.
- i_wdata  in  SIZE_DATA  write byte. Sampled with i_start.
- o_rdata  out  SIZE_DATA  read byte. Valid from o_done, held until next read completes.
- o_busy  out  1  high from the cycle after acceptance through the o_done cycle.
- o_done  out  1  one-cycle completion pulse.
- o_ack_err  out  1  slave NACKed address or write data. Valid with o_done, held until next accept.
- TWI_SCL  out  1  bus clock.
- TWI_SDA  inout  1  bus data. Drives 0 when the internal pull is active, otherwise 'z'.

Behaviour:
- Reset values: o_rdata=0, o_busy=0, o_done=0, o_ack_err=0, TWI_SCL=1, SDA released, state IDLE, counters 0.
- Reset asserted mid-transaction: next edge returns to IDLE with SCL=1 and SDA released. No STOP is generated.
- Quarter tick: counter 0..CLK_DIV-1 runs only while not IDLE. The tick fires when the count equals CLK_DIV-1. A quarter index q0..q3 advances on each tick.
- Data bit (per bit slot):
  - q0, q1: SCL=0. SDA changes only at entry to q0.
  - q2, q3: SCL=1.
  - SDA is sampled on the last i_clk cycle of q2.
- States and transitions:
  - IDLE: on i_start, latch {i_addr, i_rw, i_wdata} and clear o_ack_err; go to START. o_busy=1 next cycle. i_start while busy is ignored, with no side effect.
  - START: SCL=1 for q0..q3. SDA released in q0..q1, pulled low in q2..q3. Then go to ADDR.
  - ADDR: 8 bit slots, MSB first: addr[6:0], then rw. Then go to AACK.
  - AACK: 1 slot, SDA released, sample.
    - Sampled 1: set o_ack_err, go to STOP.
    - Sampled 0 with rw=0: go to WDATA.
    - Sampled 0 with rw=1: go to RDATA.
  - WDATA: 8 slots, MSB first. Then go to WACK.
  - WACK: 1 slot, SDA released. Sampled 1 sets o_ack_err. Then go to STOP.
  - RDATA: 8 slots, SDA released. Shift in the sampled bit, MSB first. Then go to RNACK.
  - RNACK: 1 slot, SDA released (master NACK, ends the read). Then go to STOP.
  - STOP: q0 SCL=0 with SDA low; q1..q2 SCL=1 with SDA low; q3 SCL=1 with SDA released. Then go to DONE.
  - DONE: o_done=1 for one cycle. o_rdata is updated from the shift register if rw=1. Then go to IDLE, where o_busy=0.
- Latency, i_start to o_done, for a full transaction: 1 + 80*CLK_DIV + 1 cycles.
  - Quarter count: START 4 + 36 address/ack + 36 data/ack + STOP 4 = 80.
  - Address NACK path: 1 + 44*CLK_DIV + 1.
- Back-to-back: i_start in the cycle after o_done (state IDLE) is accepted.
- Bit counter: 3-bit, wraps 7 to 0 at the byte boundary. No clock stretching and no arbitration.

Decomposition:
- Package twi_pkg:
  - State enum: IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP, DONE.
  - Constants SIZE_ADDR and SIZE_DATA.
  - Quarter enum q0..q3.
  - The slave imports the same package.
- Sub-module twi_qtick: divider producing the quarter tick and quarter index. It has an enable input and is cleared when in IDLE.

Test Plan:
- Write: CLK_DIV=4, addr 0x01, rw=0, wdata 0xA5, slave model ACKs.
  - SDA bits 0000001_0 then 10100101. START/STOP edges correct. SCL period 16 cycles.
  - o_done at cycle 322. o_ack_err=0.
- Read: addr 0x01, rw=1, slave drives 0x3C.
  - o_rdata=0x3C at o_done. Master leaves SDA released in the 9th slot. STOP follows.
- Address NACK: addr 0x55, no slave response.
  - o_ack_err=1. No data slots; STOP directly after AACK. o_done at cycle 178.
- Write NACK: slave ACKs address, NACKs data 0xFF.
  - o_ack_err=1 with o_done. Full 80-quarter length.
- Busy and reset: i_start pulsed again mid-transaction, ignored (latched values unchanged). i_rst_n=0 during the RDATA slot 3.
  - Next cycle: SCL=1, SDA='z', o_busy=0, o_rdata=0.
- Back-to-back: second i_start one cycle after o_done.
  - Accepted. Second START begins 1 cycle later. o_ack_err cleared.

Source files
------------

// File: rtl/twi_pkg.sv
// rtl/twi_pkg.sv - shared TWI types, widths and bus pin encoding
package twi_pkg;

    localparam int SIZE_ADDR = 7;
    localparam int SIZE_DATA = 8;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP, DONE
    } twi_state_t;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} twi_quarter_t;

    // Returns {scl, sda_pull} for a given position on the bus.
    function automatic logic [1:0] twi_pins(input twi_state_t st, input twi_quarter_t q,
                                            input logic tx_bit);
        logic       hi;
        logic [1:0] p;
        hi = (q == Q2) || (q == Q3);
        case (st)
            START:                    p = {1'b1, hi};
            ADDR, WDATA:              p = {hi, ~tx_bit};
            AACK, WACK, RDATA, RNACK: p = {hi, 1'b0};
            STOP:                     p = {q != Q0, q != Q3};
            default:                  p = 2'b10;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/twi_qtick.sv
// rtl/twi_qtick.sv - SCL quarter-period divider with quarter index
module twi_qtick
    import twi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         en,
    output logic         tick,
    output twi_quarter_t quarter
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !en) begin
            cnt     <= '0;
            quarter <= Q0;
        end else if (tick) begin
            cnt     <= '0;
            quarter <= twi_quarter_t'(quarter + 2'd1);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/twi_master.sv
// rtl/twi_master.sv - single-byte TWI master: START, addr+rw, one data byte, STOP
module twi_master #(
    parameter int SIZE_ADDR = twi_pkg::SIZE_ADDR,
    parameter int SIZE_DATA = twi_pkg::SIZE_DATA,
    parameter int CLK_DIV   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_rw,
    input  logic [SIZE_ADDR-1:0] i_addr,
    input  logic [SIZE_DATA-1:0] i_wdata,
    output logic [SIZE_DATA-1:0] o_rdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_ack_err,
    output logic                 TWI_SCL,
    inout  wire                  TWI_SDA
);

    import twi_pkg::*;

    twi_state_t           state, st_nx, pos_st;
    twi_quarter_t         quarter, pos_q;
    logic                 tick, slot_end, sample;
    logic [2:0]           bit_cnt, bit_nx, pos_bit;
    logic [SIZE_ADDR-1:0] addr_r;
    logic                 rw_r;
    logic [SIZE_DATA-1:0] wdata_r, shift_r;
    logic [SIZE_ADDR:0]   frame;
    logic                 sda_s, scl_r, pull_r;
    logic                 tx_bit, scl_nx, pull_nx;

    twi_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (state != IDLE),
        .tick    (tick),
        .quarter (quarter)
    );

    assign frame    = {addr_r, rw_r};
    assign slot_end = tick && (quarter == Q3);
    assign sample   = tick && (quarter == Q2);
    assign TWI_SCL  = scl_r;
    assign TWI_SDA  = pull_r ? 1'b0 : 1'bz;

    // Where the FSM goes when the current bit slot ends, and the pins for the next quarter.
    always_comb begin
        st_nx  = state;
        bit_nx = bit_cnt;
        case (state)
            START: st_nx = ADDR;
            ADDR: begin
                bit_nx = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) st_nx = AACK;
            end
            AACK:  st_nx = sda_s ? STOP : (rw_r ? RDATA : WDATA);
            WDATA: begin
                bit_nx = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) st_nx = WACK;
            end
            WACK:  st_nx = STOP;
            RDATA: begin
                bit_nx = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) st_nx = RNACK;
            end
            RNACK: st_nx = STOP;
            STOP:  st_nx = DONE;
            default: st_nx = state;
        endcase
        pos_st  = slot_end ? st_nx : state;
        pos_bit = slot_end ? bit_nx : bit_cnt;
        pos_q   = twi_quarter_t'(quarter + 2'd1);
        tx_bit  = (pos_st == ADDR) ? frame[~pos_bit] : wdata_r[~pos_bit];
        {scl_nx, pull_nx} = twi_pins(pos_st, pos_q, tx_bit);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            addr_r    <= '0;
            rw_r      <= 1'b0;
            wdata_r   <= '0;
            shift_r   <= '0;
            sda_s     <= 1'b1;
            scl_r     <= 1'b1;
            pull_r    <= 1'b0;
            o_rdata   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_ack_err <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    // o_busy still high here means this is the o_done cycle.
                    if (o_busy) begin
                        o_busy <= 1'b0;
                    end else if (i_start) begin
                        addr_r    <= i_addr;
                        rw_r      <= i_rw;
                        wdata_r   <= i_wdata;
                        o_ack_err <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= START;
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    if (rw_r && !o_ack_err) o_rdata <= shift_r;
                    state <= IDLE;
                end
                default: begin
                    if (slot_end) begin
                        state   <= st_nx;
                        bit_cnt <= bit_nx;
                    end
                end
            endcase
            if (sample) begin
                sda_s <= TWI_SDA;
                if (state == RDATA) shift_r <= {shift_r[SIZE_DATA-2:0], TWI_SDA};
                if ((state == AACK || state == WACK) && TWI_SDA) o_ack_err <= 1'b1;
            end
            if (tick) begin
                scl_r  <= scl_nx;
                pull_r <= pull_nx;
            end
        end
    end

endmodule
